// File: rtl/pcn_sync.sv
// Stochastic-decoder parity-check node: registered extrinsic outputs plus a
// satisfied-run lock detector and a saturating unsatisfied-cycle counter.
module pcn_sync #(
  parameter int DEG     = 6,
  parameter int SAT_RUN = 16,
  parameter int CW      = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           EN,
  input  logic           CLR,
  input  logic [DEG-1:0] Q,
  output logic [DEG-1:0] R,
  output logic           PAR,
  output logic           PC_sat,
  output logic           LOCK_P,
  output logic [CW-1:0]  UNSAT_CNT
);

  localparam int RW = $clog2(SAT_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(SAT_RUN);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t          r_state;
  logic [DEG-1:0]  r_r;
  logic            r_par;
  logic            r_lock_p;
  logic [RW-1:0]   r_run;
  logic [CW-1:0]   r_unsat;

  logic            w_p;
  logic [RW-1:0]   w_run_inc;

  assign w_p       = ^Q;
  assign w_run_inc = (r_run == RUN_MAX) ? r_run : r_run + RW'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= SEARCH;
      r_r      <= '0;
      r_par    <= 1'b0;
      r_lock_p <= 1'b0;
      r_run    <= '0;
      r_unsat  <= '0;
    end else if (CLR) begin
      r_state  <= SEARCH;
      r_r      <= '0;
      r_par    <= 1'b0;
      r_lock_p <= 1'b0;
      r_run    <= '0;
      r_unsat  <= '0;
    end else if (EN) begin
      // Extrinsic bit excludes the edge's own contribution: p ^ Q[i]
      r_r   <= {DEG{w_p}} ^ Q;
      r_par <= w_p;
      if (w_p) begin
        r_run    <= '0;
        r_state  <= SEARCH;
        r_lock_p <= 1'b0;
        if (r_unsat != {CW{1'b1}})
          r_unsat <= r_unsat + CW'(1);
      end else begin
        r_run <= w_run_inc;
        if (r_state == SEARCH && w_run_inc == RUN_MAX) begin
          r_state  <= LOCKED;
          r_lock_p <= 1'b1;
        end else begin
          r_lock_p <= 1'b0;
        end
      end
    end else begin
      // Disabled cycles are transparent to the run; only the pulse drops
      r_lock_p <= 1'b0;
    end
  end

  assign R         = r_r;
  assign PAR       = r_par;
  assign PC_sat    = (r_state == LOCKED);
  assign LOCK_P    = r_lock_p;
  assign UNSAT_CNT = r_unsat;

endmodule
